// File: rtl/i2c_arbitro.sv
// i2c_arbitro: round-robin arbiter that shares one I2C command generator
// among N_REQ requesters. It latches the winner's command, holds start_stb
// until the generator reports busy, waits for completion (or a timeout) and
// returns a one-cycle done pulse to the granted requester.
module i2c_arbitro #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_rnw,
  input  logic [7*N_REQ-1:0]    req_addr,
  input  logic [16*N_REQ-1:0]   req_wr_data,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  timeout_err,
  output logic [15:0]           rd_data_out,
  output logic                  start_stb,
  output logic                  rnw,
  output logic [6:0]            i2c_addr1,
  output logic [15:0]           wr_data,
  input  logic [15:0]           rd_data,
  input  logic                  gen_busy
);

  localparam int            IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]    TO_LIMIT = 8'(TIMEOUT);
  localparam logic [IW-1:0] PTR_INIT = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t             state_r;
  logic [7:0]         cnt_r;
  logic [IW-1:0]      ptr_r;
  logic [IW-1:0]      idx_r;

  logic               pick_valid_s;
  logic [IW-1:0]      pick_idx_s;
  logic [N_REQ-1:0]   onehot_s;
  logic [N_REQ-1:0]   rnw_sh_s;
  logic [7*N_REQ-1:0] addr_sh_s;
  logic [16*N_REQ-1:0] wdat_sh_s;

  // Round-robin search starting at p+1. The loop runs from the farthest
  // candidate down to the nearest so the nearest asserted request wins.
  // A request bit that is X compares as not-equal to 1 and is skipped.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input logic [IW-1:0]    p);
    logic [N_REQ-1:0] sh;
    logic [IW:0]      res;
    int               c;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      c  = (int'(p) + k) % N_REQ;
      sh = r >> c;
      if (sh[0] == 1'b1) begin
        res = {1'b1, c[IW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Winner selection and extraction of the winner's command fields.
  always_comb begin
    {pick_valid_s, pick_idx_s} = rr_pick(req, ptr_r);
    onehot_s  = N_REQ'(1) << pick_idx_s;
    rnw_sh_s  = req_rnw >> pick_idx_s;
    addr_sh_s = req_addr >> (7 * int'(pick_idx_s));
    wdat_sh_s = req_wr_data >> (16 * int'(pick_idx_s));
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      ptr_r       <= PTR_INIT;
      idx_r       <= '0;
      gnt         <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      rd_data_out <= 16'd0;
      start_stb   <= 1'b0;
      rnw         <= 1'b0;
      i2c_addr1   <= 7'd0;
      wr_data     <= 16'd0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            gnt       <= onehot_s;
            idx_r     <= pick_idx_s;
            rnw       <= rnw_sh_s[0];
            i2c_addr1 <= addr_sh_s[6:0];
            wr_data   <= wdat_sh_s[15:0];
            start_stb <= 1'b1;
            cnt_r     <= 8'd0;
            state_r   <= LAUNCH;
          end else begin
            state_r   <= IDLE;
          end
        end
        LAUNCH: begin
          // Timeout has priority here: the strobe was never accepted.
          if (cnt_r == TO_LIMIT) begin
            done        <= gnt;
            timeout_err <= 1'b1;
            start_stb   <= 1'b0;
            state_r     <= RELEASE;
          end else if (gen_busy) begin
            start_stb   <= 1'b0;
            state_r     <= WAIT_DONE;
          end else begin
            state_r     <= LAUNCH;
          end
          if (cnt_r != 8'hFF) cnt_r <= cnt_r + 8'd1;
          else                cnt_r <= cnt_r;
        end
        WAIT_DONE: begin
          // Normal completion wins over a coincident timeout.
          if (!gen_busy) begin
            done <= gnt;
            if (rnw) rd_data_out <= rd_data;
            else     rd_data_out <= rd_data_out;
            state_r <= RELEASE;
          end else if (cnt_r == TO_LIMIT) begin
            done        <= gnt;
            timeout_err <= 1'b1;
            start_stb   <= 1'b0;
            state_r     <= RELEASE;
          end else begin
            state_r     <= WAIT_DONE;
          end
          if (cnt_r != 8'hFF) cnt_r <= cnt_r + 8'd1;
          else                cnt_r <= cnt_r;
        end
        RELEASE: begin
          gnt     <= '0;
          ptr_r   <= idx_r;
          state_r <= IDLE;
        end
        default: begin
          gnt       <= '0;
          start_stb <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_arbitro.md
I2C_ARBITRO -- requirements
Module: i2c_arbitro

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters sharing one I2C generator.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: the maximum number of clk cycles spent in LAUNCH or WAIT_DONE.
REQ-003 clk  in  1  single system clock, the same clock that drives the generator; all logic rises on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 req  in  N_REQ  per-requester request level.
REQ-006 req_rnw  in  N_REQ  per-requester read(1)/write(0).
REQ-007 req_addr  in  7*N_REQ  per-requester 7-bit target address; requester i uses bits [7i+6:7i].
REQ-008 req_wr_data  in  16*N_REQ  per-requester write word; requester i uses bits [16i+15:16i].
REQ-009 gnt  out  N_REQ  one-hot grant, held for the whole transaction.
REQ-010 done  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-011 timeout_err  out  1  one-cycle pulse, coincident with done, when a transaction times out.
REQ-012 rd_data_out  out  16  read word returned by the generator; valid when done pulses.
REQ-013 start_stb, rnw, i2c_addr1[6:0], wr_data[15:0]  out  generator command lines, all registered.
REQ-014 rd_data  in  16  read word from the generator.
REQ-015 gen_busy  in  1  high while the generator is outside its IDLE state.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_DONE and RELEASE.
REQ-017 In IDLE with any req bit high, the block SHALL select a winner i by round-robin, searching from ptr+1 upward modulo N_REQ.
REQ-018 On that same edge, the block SHALL register gnt=one-hot(i), rnw=req_rnw[i], i2c_addr1=req_addr[i] and wr_data=req_wr_data[i].
REQ-019 On that same edge, the block SHALL set start_stb=1, clear the timeout counter and go to LAUNCH; gnt and start_stb are visible one cycle after req is sampled.
REQ-020 In LAUNCH, start_stb SHALL stay 1 until gen_busy=1 is sampled; on that edge start_stb<=0 and the FSM goes to WAIT_DONE. Holding start_stb covers the generator's divided internal clock.
REQ-021 In WAIT_DONE, when gen_busy=0 is sampled, the block SHALL register rd_data_out<=rd_data (when rnw=1 only) and pulse done[i] for one cycle. On that edge it goes to RELEASE.
REQ-022 In RELEASE, the block SHALL clear gnt, set ptr<=i and return to IDLE; a new grant is possible no earlier than the cycle after RELEASE.
REQ-023 Command outputs (rnw, i2c_addr1, wr_data) SHALL stay constant from grant until RELEASE, regardless of changes on req_* inputs.
REQ-024 The req lines SHALL be sampled only in IDLE; a req drop during LAUNCH or WAIT_DONE SHALL NOT abort the transaction.
REQ-025 Timeout counter: 8-bit, increments each cycle in LAUNCH and WAIT_DONE, saturates, cleared on entry to LAUNCH.
REQ-026 When the counter equals TIMEOUT, the block SHALL pulse done[i] and timeout_err together, set start_stb<=0, leave rd_data_out unchanged and go to RELEASE.
REQ-027 If gen_busy=0 and the counter reaches TIMEOUT on the same edge in WAIT_DONE, normal completion SHALL win and timeout_err SHALL stay 0.
REQ-028 Any idle cycle SHALL NOT change ptr; with a single requester asserting continuously, that requester SHALL be regranted every transaction.
REQ-029 Out-of-range or X req bits SHALL NOT be granted: only bits 0..N_REQ-1 participate.
REQ-030 At most one gnt bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-031 With reset=1 at a posedge, the block SHALL set state=IDLE, gnt=0, done=0, timeout_err=0, start_stb=0, rnw=0, i2c_addr1=0, wr_data=0, rd_data_out=0, counter=0 and ptr=N_REQ-1, so requester 0 has first priority.
REQ-032 Reset mid-transaction SHALL drop start_stb and gnt on the next edge and SHALL produce no done pulse.
REQ-033 The first grant after reset deasserts SHALL be possible on the first edge with reset=0 and req!=0.

Verification
REQ-034 Single write: req=0001, req_rnw[0]=0, addr0=7'h2A, wr0=16'hBEEF -> gnt=0001, i2c_addr1=2A, wr_data=BEEF and start_stb high until gen_busy rises; done[0] pulses 1 cycle after gen_busy falls; then gnt=0.
REQ-035 Single read: req=0100, rnw=1, model returns rd_data=16'hAAAA -> rd_data_out=AAAA with done[2]; timeout_err=0.
REQ-036 Contention after reset: req=1111 held for 4 transactions -> grant order 0,1,2,3, then 0 again; never two gnt bits high.
REQ-037 Timeout: gen_busy stuck 0 in LAUNCH -> after TIMEOUT=255 cycles, done[i] and timeout_err pulse together; rd_data_out unchanged; FSM back in IDLE 2 cycles later.
REQ-038 Reset mid-WAIT_DONE: reset=1 for 1 cycle -> all outputs 0 next edge, no done pulse, next req=0010 granted immediately.
REQ-039 Input churn: change req_addr[i] and drop req[i] during WAIT_DONE -> i2c_addr1 stays at the latched value and done[i] still pulses.
